// File: rtl/layer_compositor_if.sv
// Pixel-stream bundle between a layer source (master) and the compositor (slave).
//   startOfFrame   : one-cycle pulse on the first pixel of a frame
//   layerDR        : per-layer drawing request
//   layerRGB       : per-layer colour, layer i at [i*COLOR_W +: COLOR_W]
//   layerEnable    : static per-layer enable mask
//   blinkMask      : layers that follow the blink phase
//   blinkPeriod    : frames per blink half-phase, 0 = no blinking
//   backGroundRGB  : colour shown when no layer wins
//   RGBOut         : composited pixel
//   topLayer       : winning layer index, NUM_LAYERS for background
//   collisionFlags : per-frame overlap of the player layer with every other layer
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 12,
    parameter int COLOR_W    = 8,
    parameter int BLINK_W    = 6
);
    localparam int TL_W = $clog2(NUM_LAYERS + 1);

    logic                          startOfFrame;
    logic [NUM_LAYERS-1:0]         layerDR;
    logic [NUM_LAYERS*COLOR_W-1:0] layerRGB;
    logic [NUM_LAYERS-1:0]         layerEnable;
    logic [NUM_LAYERS-1:0]         blinkMask;
    logic [BLINK_W-1:0]            blinkPeriod;
    logic [COLOR_W-1:0]            backGroundRGB;
    logic [COLOR_W-1:0]            RGBOut;
    logic [TL_W-1:0]               topLayer;
    logic [NUM_LAYERS-1:0]         collisionFlags;

    modport master (
        output startOfFrame, layerDR, layerRGB, layerEnable, blinkMask,
               blinkPeriod, backGroundRGB,
        input  RGBOut, topLayer, collisionFlags
    );

    modport slave (
        input  startOfFrame, layerDR, layerRGB, layerEnable, blinkMask,
               blinkPeriod, backGroundRGB,
        output RGBOut, topLayer, collisionFlags
    );
endinterface

// File: rtl/layer_compositor.sv
// Priority layer compositor with blinking and player-collision tracking.
// Two-stage pipeline: stage 1 registers the qualified-active vector plus all
// colours, stage 2 picks the lowest-index active layer. Latency 2, 1 pixel/clk.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : layer_compositor_if.slave (pixel inputs, composited outputs)
module layer_compositor #(
    parameter int                 NUM_LAYERS   = 12,
    parameter int                 COLOR_W      = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT  = COLOR_W'(8'hFF),
    parameter int                 PLAYER_LAYER = 5,
    parameter int                 BLINK_W      = 6
) (
    input logic               clk,
    input logic               reset,
    layer_compositor_if.slave bus
);
    localparam int              TL_W     = $clog2(NUM_LAYERS + 1);
    localparam logic [TL_W-1:0] TOP_NONE = TL_W'(NUM_LAYERS);

    generate
        if (NUM_LAYERS < 2 || PLAYER_LAYER < 0 || PLAYER_LAYER >= NUM_LAYERS) begin : g_bad_params
            $error("layer_compositor: need NUM_LAYERS >= 2 and 0 <= PLAYER_LAYER < NUM_LAYERS");
        end
    endgenerate

    // stage 1
    logic [NUM_LAYERS-1:0]         active_d, active_q;
    logic [NUM_LAYERS*COLOR_W-1:0] rgb_d, rgb_q;
    logic [COLOR_W-1:0]            bg_d, bg_q;
    // stage 2
    logic [COLOR_W-1:0]            rgb_out_d, rgb_out_q;
    logic [TL_W-1:0]               top_layer_d, top_layer_q;
    // blink
    logic [BLINK_W-1:0]            blink_cnt_d, blink_cnt_q;
    logic                          blink_phase_d, blink_phase_q;
    // collision
    logic [NUM_LAYERS-1:0]         hit;
    logic [NUM_LAYERS-1:0]         coll_acc_d, coll_acc_q;
    logic [NUM_LAYERS-1:0]         coll_flags_d, coll_flags_q;

    always_comb begin
        active_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            active_d[i] = bus.layerDR[i]
                       && bus.layerEnable[i]
                       && (bus.layerRGB[i*COLOR_W +: COLOR_W] != TRANSPARENT)
                       && !(bus.blinkMask[i] && blink_phase_q);
        end
        rgb_d = bus.layerRGB;
        bg_d  = bus.backGroundRGB;
    end

    // Scan from the highest index down so the lowest active index is the last write.
    always_comb begin
        rgb_out_d   = bg_q;
        top_layer_d = TOP_NONE;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (active_q[i]) begin
                rgb_out_d   = rgb_q[i*COLOR_W +: COLOR_W];
                top_layer_d = TL_W'(i);
            end
        end
    end

    // The ">=" compare lets a counter that is already past a newly shortened
    // period wrap on the very next frame instead of running round the full width.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (bus.blinkPeriod == '0) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (bus.startOfFrame) begin
            if (blink_cnt_q >= (bus.blinkPeriod - BLINK_W'(1))) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // A hit seen on the capture cycle goes straight into the captured flags and
    // the accumulator restarts empty, so it never leaks into the next frame.
    always_comb begin
        hit = '0;
        if (active_q[PLAYER_LAYER]) begin
            hit = active_q;
        end
        hit[PLAYER_LAYER] = 1'b0;

        coll_acc_d   = coll_acc_q | hit;
        coll_flags_d = coll_flags_q;
        if (bus.startOfFrame) begin
            coll_flags_d = coll_acc_q | hit;
            coll_acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q      <= '0;
            rgb_q         <= '0;
            bg_q          <= '0;
            rgb_out_q     <= '0;
            top_layer_q   <= TOP_NONE;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            coll_acc_q    <= '0;
            coll_flags_q  <= '0;
        end else begin
            active_q      <= active_d;
            rgb_q         <= rgb_d;
            bg_q          <= bg_d;
            rgb_out_q     <= rgb_out_d;
            top_layer_q   <= top_layer_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            coll_acc_q    <= coll_acc_d;
            coll_flags_q  <= coll_flags_d;
        end
    end

    assign bus.RGBOut         = rgb_out_q;
    assign bus.topLayer       = top_layer_q;
    assign bus.collisionFlags = coll_flags_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: a default 12-layer/8-bit instance and a
// 2-layer/12-bit instance (player layer 1) sharing clock and reset.
module tb_layer_compositor;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    layer_compositor_if #(.NUM_LAYERS(12), .COLOR_W(8),  .BLINK_W(6)) bus_a ();
    layer_compositor_if #(.NUM_LAYERS(2),  .COLOR_W(12), .BLINK_W(6)) bus_b ();

    layer_compositor dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    layer_compositor #(
        .NUM_LAYERS   (2),
        .COLOR_W      (12),
        .TRANSPARENT  (12'hFFF),
        .PLAYER_LAYER (1),
        .BLINK_W      (6)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_a();
        bus_a.startOfFrame = 1'b1;
        step();
        bus_a.startOfFrame = 1'b0;
    endtask

    task automatic sof_b();
        bus_b.startOfFrame = 1'b1;
        step();
        bus_b.startOfFrame = 1'b0;
    endtask

    task automatic pix_a(input string tag, input logic [11:0] dr, input logic [7:0] e_rgb, input logic [3:0] e_top);
        bus_a.layerDR = dr;
        step();
        step();
        check_val({tag, "_rgb"}, 32'(bus_a.RGBOut), 32'(e_rgb));
        check_val({tag, "_top"}, 32'(bus_a.topLayer), 32'(e_top));
    endtask

    task automatic pix_b(input string tag, input logic [1:0] dr, input logic [11:0] e_rgb, input logic [1:0] e_top);
        bus_b.layerDR = dr;
        step();
        step();
        check_val({tag, "_rgb"}, 32'(bus_b.RGBOut), 32'(e_rgb));
        check_val({tag, "_top"}, 32'(bus_b.topLayer), 32'(e_top));
    endtask

    initial begin
        logic vis;
        reset                = 1'b1;
        bus_a.startOfFrame   = 1'b0;
        bus_a.layerDR        = '0;
        bus_a.layerRGB       = '0;
        bus_a.layerEnable    = 12'hFFF;
        bus_a.blinkMask      = '0;
        bus_a.blinkPeriod    = '0;
        bus_a.backGroundRGB  = 8'h40;
        bus_b.startOfFrame   = 1'b0;
        bus_b.layerDR        = '0;
        bus_b.layerRGB       = {12'h123, 12'hABC};
        bus_b.layerEnable    = 2'b11;
        bus_b.blinkMask      = '0;
        bus_b.blinkPeriod    = '0;
        bus_b.backGroundRGB  = 12'h555;

        step(); step(); step();
        check_val("rst_rgb",   32'(bus_a.RGBOut),         32'h0);
        check_val("rst_top",   32'(bus_a.topLayer),       32'd12);
        check_val("rst_flags", 32'(bus_a.collisionFlags), 32'h0);
        check_val("rst_top_b", 32'(bus_b.topLayer),       32'd2);
        reset = 1'b0;

        // priority
        bus_a.layerRGB[3*8 +: 8]  = 8'h1C;
        bus_a.layerRGB[7*8 +: 8]  = 8'hE0;
        bus_a.layerRGB[0*8 +: 8]  = 8'h11;
        bus_a.layerRGB[11*8 +: 8] = 8'hBB;
        pix_a("pri_3_7",  12'h088, 8'h1C, 4'd3);
        pix_a("l7_only",  12'h080, 8'hE0, 4'd7);
        pix_a("l0_l11",   12'h801, 8'h11, 4'd0);
        pix_a("l11_only", 12'h800, 8'hBB, 4'd11);
        pix_a("none",     12'h000, 8'h40, 4'd12);

        // back-to-back pixels: exact 2-clock latency, no bubbles
        bus_a.layerDR = 12'h008; step();
        bus_a.layerDR = 12'h080; step();
        check_val("tp0_rgb", 32'(bus_a.RGBOut), 32'h1C);
        bus_a.layerDR = 12'h000; step();
        check_val("tp1_rgb", 32'(bus_a.RGBOut), 32'hE0);
        check_val("tp1_top", 32'(bus_a.topLayer), 32'd7);
        step();
        check_val("tp2_top", 32'(bus_a.topLayer), 32'd12);

        // transparency and enable
        bus_a.layerRGB[0*8 +: 8] = 8'hFF;
        bus_a.layerRGB[2*8 +: 8] = 8'h03;
        bus_a.layerEnable        = 12'hFFB;
        pix_a("transp_en", 12'h005, 8'h40, 4'd12);
        bus_a.layerRGB[0*8 +: 8] = 8'h11;
        bus_a.layerEnable        = 12'hFFF;
        pix_a("en_on", 12'h004, 8'h03, 4'd2);

        // blink, period 2: frames 0-1 visible, 2-3 hidden, 4-5 visible, 6 hidden
        bus_a.layerRGB[4*8 +: 8] = 8'h2A;
        bus_a.blinkMask          = 12'h010;
        bus_a.blinkPeriod        = 6'd2;
        pix_a("blink_f0", 12'h010, 8'h2A, 4'd4);
        for (int f = 1; f <= 6; f++) begin
            sof_a();
            vis = (f == 1) || (f == 4) || (f == 5);
            pix_a($sformatf("blink_f%0d", f), 12'h010, vis ? 8'h2A : 8'h40, vis ? 4'd4 : 4'd12);
        end
        bus_a.blinkPeriod = 6'd0;
        step();
        pix_a("blink_off", 12'h010, 8'h2A, 4'd4);
        bus_a.blinkMask = '0;
        bus_a.layerDR   = '0;

        // collisions, player layer 5
        bus_a.layerRGB[5*8 +: 8] = 8'h55;
        bus_a.layerRGB[9*8 +: 8] = 8'h99;
        step();
        sof_a();
        check_val("coll_clear", 32'(bus_a.collisionFlags), 32'h0);
        bus_a.layerDR = 12'h220; step();
        bus_a.layerDR = 12'h000; step(); step();
        check_val("coll_pre", 32'(bus_a.collisionFlags), 32'h0);
        sof_a();
        check_val("coll_cap", 32'(bus_a.collisionFlags), 32'h200);
        step(); step(); step();
        check_val("coll_hold", 32'(bus_a.collisionFlags), 32'h200);
        sof_a();
        check_val("coll_next", 32'(bus_a.collisionFlags), 32'h0);

        bus_a.layerRGB[9*8 +: 8] = 8'hFF;
        bus_a.layerDR = 12'h220; step();
        bus_a.layerDR = 12'h000; step();
        sof_a();
        check_val("coll_transp", 32'(bus_a.collisionFlags), 32'h0);
        bus_a.layerRGB[9*8 +: 8] = 8'h99;

        bus_a.layerDR = 12'h024; step();
        bus_a.layerDR = 12'h000;
        sof_a();
        check_val("coll_same", 32'(bus_a.collisionFlags), 32'h004);
        step();
        sof_a();
        check_val("coll_nocarry", 32'(bus_a.collisionFlags), 32'h0);

        bus_a.layerDR = 12'h821; step();
        bus_a.layerDR = 12'h000; step();
        sof_a();
        check_val("coll_edges", 32'(bus_a.collisionFlags), 32'h801);

        // reset mid-stream
        pix_a("pre_rst", 12'h008, 8'h1C, 4'd3);
        reset = 1'b1;
        step();
        check_val("mrst_rgb",   32'(bus_a.RGBOut),         32'h0);
        check_val("mrst_top",   32'(bus_a.topLayer),       32'd12);
        check_val("mrst_flags", 32'(bus_a.collisionFlags), 32'h0);
        reset = 1'b0;
        step();
        check_val("rel1_rgb", 32'(bus_a.RGBOut),   32'h0);
        check_val("rel1_top", 32'(bus_a.topLayer), 32'd12);
        step();
        check_val("rel2_rgb", 32'(bus_a.RGBOut),   32'h1C);
        check_val("rel2_top", 32'(bus_a.topLayer), 32'd3);
        bus_a.layerDR = '0;

        // 2-layer, 12-bit instance
        pix_b("p2_pri", 2'b11, 12'hABC, 2'd0);
        pix_b("p2_l1",  2'b10, 12'h123, 2'd1);
        pix_b("p2_bg",  2'b00, 12'h555, 2'd2);
        bus_b.layerRGB[11:0] = 12'hFFF;
        pix_b("p2_transp", 2'b01, 12'h555, 2'd2);
        bus_b.layerRGB[11:0] = 12'hABC;
        bus_b.layerDR = 2'b00;
        sof_b();
        check_val("p2_coll_pri", 32'(bus_b.collisionFlags), 32'h1);
        sof_b();
        check_val("p2_coll_clr", 32'(bus_b.collisionFlags), 32'h0);
        bus_b.layerDR = 2'b11; step();
        bus_b.layerDR = 2'b00; step();
        sof_b();
        check_val("p2_coll_cap", 32'(bus_b.collisionFlags), 32'h1);
        sof_b();
        check_val("p2_coll_next", 32'(bus_b.collisionFlags), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 The block SHALL take parameter NUM_LAYERS, default 12, meaning the number of drawable layers; index 0 is the highest priority.
REQ-002 The block SHALL take parameter COLOR_W, default 8, meaning the RGB pixel width.
REQ-003 The block SHALL take parameter TRANSPARENT, default 8'hFF (COLOR_W bits), meaning the colour key treated as "not drawing".
REQ-004 The block SHALL take parameter PLAYER_LAYER, default 5, meaning the layer index used for collision tracking.
REQ-005 The block SHALL take parameter BLINK_W, default 6, meaning the width of the blink period.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 clk  in  1  system clock; all state on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
REQ-010 layerDR  in  NUM_LAYERS  per-layer drawing request.
REQ-011 layerRGB  in  NUM_LAYERS*COLOR_W  per-layer colour; layer i occupies bits [i*COLOR_W +: COLOR_W].
REQ-012 layerEnable  in  NUM_LAYERS  static per-layer enable mask.
REQ-013 blinkMask  in  NUM_LAYERS  layers subject to blinking.
REQ-014 blinkPeriod  in  BLINK_W  frames per blink half-phase; 0 disables blinking.
REQ-015 backGroundRGB  in  COLOR_W  colour used when no layer wins.
REQ-016 RGBOut  out  COLOR_W  composited pixel.
REQ-017 topLayer  out  $clog2(NUM_LAYERS+1)  index of the winning layer; NUM_LAYERS when background wins.
REQ-018 collisionFlags  out  NUM_LAYERS  per-frame overlap of PLAYER_LAYER with each other layer.

Function
REQ-019 Qualification SHALL be computed as follows: layer i is active iff layerDR[i] AND layerEnable[i] AND its RGB != TRANSPARENT AND NOT (blinkMask[i] AND blinkPhase).
REQ-020 Stage 1 SHALL register the active vector, all layer RGBs and backGroundRGB.
REQ-021 Stage 2 SHALL register RGBOut and topLayer from the lowest-index active layer; with no active layer, RGBOut SHALL be backGroundRGB and topLayer SHALL be NUM_LAYERS.
REQ-022 Latency SHALL be exactly 2 clocks from the inputs to RGBOut/topLayer, with no bubbles and a throughput of 1 pixel per clock.
REQ-023 The blink counter (BLINK_W bits) SHALL increment on each startOfFrame.
REQ-024 When the blink counter reaches blinkPeriod-1 on a startOfFrame, it SHALL wrap to 0 and blinkPhase SHALL toggle.
REQ-025 When blinkPeriod==0, the blink counter SHALL be held at 0 and blinkPhase SHALL be held at 0.
REQ-026 When blinkPeriod is changed mid-count, a counter value >= blinkPeriod-1 SHALL wrap on the next startOfFrame.
REQ-027 Collision accumulator: for each i != PLAYER_LAYER, bit i SHALL be set when layers i and PLAYER_LAYER are both active in the same stage-1 pixel.
REQ-028 Collision accumulator bit PLAYER_LAYER SHALL always be 0.
REQ-029 On startOfFrame, collisionFlags SHALL load the accumulator, including any hit from the same cycle, and the accumulator SHALL clear.
REQ-030 collisionFlags SHALL be held constant for the whole following frame.
REQ-031 When a hit coincides with the startOfFrame capture, that hit SHALL be reported in the capture and SHALL NOT carry into the next frame.
REQ-032 The block SHALL be correct for every NUM_LAYERS >= 2, and PLAYER_LAYER SHALL be < NUM_LAYERS (checked at elaboration).

Reset
REQ-033 While reset is high, the pipeline registers, RGBOut, topLayer (forced to NUM_LAYERS), blink counter, blinkPhase, accumulator and collisionFlags SHALL be 0.
REQ-034 Reset mid-frame SHALL discard in-flight pixels, and the first valid output SHALL appear 2 clocks after reset deasserts.
REQ-035 The block SHALL not assume a startOfFrame pulse is present during reset.

Verification
REQ-036 Priority: layers 3 and 7 both drawing with RGB 8'h1C/8'hE0 -> RGBOut=8'h1C, topLayer=3 two clocks later.
REQ-037 Transparency/enable: layer 0 drawing 8'hFF and layer 2 drawing 8'h03 with layerEnable[2]=0 -> RGBOut=backGroundRGB, topLayer=12.
REQ-038 Blink: blinkPeriod=2, blinkMask[4]=1, layer 4 drawing continuously -> the layer is visible for frames 0-1, hidden for frames 2-3, and visible again for frame 4.
REQ-039 Collision: layer 5 and layer 9 overlap on one pixel in frame N -> collisionFlags=12'h200 after the next startOfFrame, and 0 after the following one if there is no overlap.
REQ-040 Reset mid-stream: assert reset for 1 clock during active drawing -> outputs 0/topLayer=12 next clock, and a correct pixel 2 clocks after release.
REQ-041 Parametrisation: rerun the priority and collision scenarios with NUM_LAYERS=2 and COLOR_W=12.
